// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter for the display path.
// Performs one shift-add-3 step per clock, with a start/busy/done handshake and
// a sticky overflow flag. Optional macro BCD_SIGNED_EN treats value as two's
// complement: the magnitude is converted and neg reports the sign.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  neg
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      bin_q;
    logic [4*DIGITS-1:0]   scratch_q;
    logic [CntW-1:0]       cnt_q;
    logic                  ovf_acc_q;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_shifted;
    logic                  ovf_hit;
    logic                  accept;
    logic                  last;
    logic [WIDTH-1:0]      load_val;

    assign accept = start && (state_q == StIdle);
    assign last   = (state_q == StShift) && (cnt_q == CntW'(1));

`ifdef BCD_SIGNED_EN
    logic load_neg;
    logic neg_pend_q;

    // Load the magnitude; -2^(WIDTH-1) negates to itself, which is correct unsigned.
    always_comb begin
        load_neg = value[WIDTH-1];
        load_val = load_neg ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
    end

    // Sign is captured on accept and published together with bcd on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_pend_q <= 1'b0;
            neg        <= 1'b0;
        end else if (accept) begin
            neg_pend_q <= load_neg;
        end else if (last) begin
            neg        <= neg_pend_q;
        end
    end
`else
    assign load_val = value;
    assign neg      = 1'b0;
`endif

    // Add 3 to every digit >= 5, then shift the next binary bit in at the bottom.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_shifted = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        // Adjusted top digit >= 8 means a carry leaves the top digit on this shift.
        ovf_hit = adj[4*DIGITS-1];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: run for exactly WIDTH shift cycles after accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == CntW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == StShift);
    end

    // Shift datapath, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bin_q     <= load_val;
                scratch_q <= '0;
                cnt_q     <= CntW'(WIDTH);
                ovf_acc_q <= 1'b0;
            end else if (state_q == StShift) begin
                bin_q     <= bin_q << 1;
                scratch_q <= scratch_shifted;
                cnt_q     <= cnt_q - 1'b1;
                ovf_acc_q <= ovf_acc_q | ovf_hit;
                if (last) begin
                    bcd  <= scratch_shifted;
                    ovf  <= ovf_acc_q | ovf_hit;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// negedge monitors pop and compare on every done pulse.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic        neg;
    } exp_t;

`ifdef BCD_SIGNED_EN
    localparam logic [39:0] ExpFf     = 40'h0000000001;
    localparam logic        ExpFfNeg  = 1'b1;
    localparam logic        Exp80Neg  = 1'b1;
    localparam logic [39:0] Exp8Ff    = 40'h0000000001;
    localparam logic        Exp8FfOvf = 1'b0;
    localparam logic        Exp8FfNeg = 1'b1;
`else
    localparam logic [39:0] ExpFf     = 40'h4294967295;
    localparam logic        ExpFfNeg  = 1'b0;
    localparam logic        Exp80Neg  = 1'b0;
    localparam logic [39:0] Exp8Ff    = 40'h0094967295;
    localparam logic        Exp8FfOvf = 1'b1;
    localparam logic        Exp8FfNeg = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start, start8;
    logic [31:0] value, value8;
    logic        busy, done, ovf, neg;
    logic [39:0] bcd;
    logic        busy8, done8, ovf8, neg8;
    logic [31:0] bcd8;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t exp8_q[$];
    exp_t mon_e, mon8_e;
    int   lat;

    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf),
        .neg   (neg)
    );

    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .value (value8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8),
        .ovf   (ovf8),
        .neg   (neg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor for the 10-digit instance.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("bcd", 64'(bcd), 64'(mon_e.bcd));
                check("ovf", 64'(ovf), 64'(mon_e.ovf));
                check("neg", 64'(neg), 64'(mon_e.neg));
            end
        end
    end

    // Monitor for the 8-digit instance.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (exp8_q.size() == 0) begin
                check("unexpected_done8", 64'(done8), 64'(0));
            end else begin
                mon8_e = exp8_q.pop_front();
                check("bcd8", 64'(bcd8), 64'(mon8_e.bcd[31:0]));
                check("ovf8", 64'(ovf8), 64'(mon8_e.ovf));
                check("neg8", 64'(neg8), 64'(mon8_e.neg));
            end
        end
    end

    // Wait for idle, then present start for one edge and record the expectation.
    task automatic issue(input logic [31:0] v, input logic [39:0] eb, input logic eo,
                         input logic en);
        exp_t e;
        int   g = 0;
        while (busy) begin
            @(posedge clk); #1;
            g++;
            if (g > 200) begin
                check("issue_timeout", 64'(busy), 64'(0));
                return;
            end
        end
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        e.bcd = eb; e.ovf = eo; e.neg = en;
        exp_q.push_back(e);
    endtask

    task automatic issue8(input logic [31:0] v, input logic [31:0] eb, input logic eo,
                          input logic en);
        exp_t e;
        int   g = 0;
        while (busy8) begin
            @(posedge clk); #1;
            g++;
            if (g > 200) begin
                check("issue8_timeout", 64'(busy8), 64'(0));
                return;
            end
        end
        start8 = 1'b1;
        value8 = v;
        @(posedge clk); #1;
        start8 = 1'b0;
        e.bcd = {8'h00, eb}; e.ovf = eo; e.neg = en;
        exp8_q.push_back(e);
    endtask

    // Counts edges from accept (edge 1) through the edge that raises done.
    task automatic wait_done(output int n);
        n = 1;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                check("done_timeout", 64'(done), 64'(1));
                return;
            end
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!done8) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                check("done8_timeout", 64'(done8), 64'(1));
                return;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        value  = '0;
        start8 = 1'b0;
        value8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_bcd", 64'(bcd), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst_neg", 64'(neg), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero and all-ones, with latency.
        issue(32'd0, 40'h0, 1'b0, 1'b0);
        wait_done(lat);
        check("lat_zero", 64'(lat), 64'(33));
        issue(32'hFFFF_FFFF, ExpFf, 1'b0, ExpFfNeg);
        wait_done(lat);
        check("lat_ff", 64'(lat), 64'(33));

        issue(32'd99, 40'h99, 1'b0, 1'b0);
        issue(32'd1000000000, 40'h1000000000, 1'b0, 1'b0);
        issue(32'd123456789, 40'h0123456789, 1'b0, 1'b0);

        // Start while busy is ignored; value changes after accept have no effect.
        issue(32'd1234, 40'h1234, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'd9999;
        @(posedge clk); #1;
        start = 1'b0;
        value = 32'd5;
        wait_done(lat);
        check("busy_in_done", 64'(busy), 64'(0));
        // Back-to-back start in the done cycle.
        issue(32'd9999, 40'h9999, 1'b0, 1'b0);
        wait_done(lat);
        check("lat_b2b", 64'(lat), 64'(33));

        // Reset mid-conversion: aborted, no done, outputs back to reset values.
        start = 1'b1;
        value = 32'd4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_bcd", 64'(bcd), 64'(0));
        check("abort_ovf", 64'(ovf), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'd56789, 40'h56789, 1'b0, 1'b0);

        // Sign-related vectors.
        issue(32'h8000_0000, 40'h2147483648, 1'b0, Exp80Neg);
        issue(32'h7FFF_FFFF, 40'h2147483647, 1'b0, 1'b0);
        wait_done(lat);

        // 8-digit instance: overflow boundaries.
        issue8(32'd123456789, 32'h23456789, 1'b1, 1'b0);
        issue8(32'd99999999, 32'h99999999, 1'b0, 1'b0);
        issue8(32'd100000000, 32'h00000000, 1'b1, 1'b0);
        issue8(32'hFFFF_FFFF, Exp8Ff[31:0], Exp8FfOvf, Exp8FfNeg);
        wait_done8();

        repeat (5) @(posedge clk);
        #1;
        check("queue_left", 64'(exp_q.size()), 64'(0));
        check("queue8_left", 64'(exp8_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
